// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write handshake and transmitter status bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic txd;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic irq_empty;
  modport master (output wr_data, wr_valid, input wr_ready, txd, busy, fifo_count, irq_empty);
  modport slave (input wr_data, wr_valid, output wr_ready, txd, busy, fifo_count, irq_empty);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even parity bit
module uart_tx_fifo #(
  parameter int CLK_DIV = 217,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, count;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic txd_q, txd_d, push, pop, tick, empty;
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = count == '0;
  assign tick = cnt_q == '0;
  assign push = bus.wr_valid && bus.wr_ready;
  assign bus.wr_ready = count != (AW+1)'(FIFO_DEPTH);
  assign bus.txd = txd_q;
  assign bus.busy = state_q != IDLE || !empty;
  assign bus.irq_empty = !bus.busy;
  assign bus.fifo_count = count;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    txd_d = txd_q;
    pop = 1'b0;
    if (state_q != IDLE) cnt_d = tick ? DW'(CLK_DIV - 1) : cnt_q - DW'(1);
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        pop = !empty;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
        txd_d = shift_q[0];
      end
      DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
        txd_d = shift_q[bit_d];
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          txd_d = ^shift_q;
`else
          state_d = STOP;
          txd_d = 1'b1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP;
        txd_d = 1'b1;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        txd_d = 1'b1;
        pop = !empty;
      end
      default: state_d = IDLE;
    endcase
    // a pop overrides the state choice so the next frame starts with no idle gap
    if (pop) begin
      state_d = START;
      shift_d = mem_q[rd_ptr_q[AW-1:0]];
      txd_d = 1'b0;
      cnt_d = DW'(CLK_DIV - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus against a queue/timing model of the transmitter
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 217;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CLK_DIV;
`else
  localparam int FRAME = 10 * CLK_DIV;
`endif
  typedef struct {logic [7:0] d; logic p; logic s; longint t;} frame_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();
  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  int failed = 0;
  longint n = 0;
  longint t0 = -64'sd1000000000;
  longint free_at = 0;
  longint starts = 0;
  logic [7:0] cur = '0;
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  frame_t rx_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // expected line level from position inside the current frame
  function automatic logic exp_txd();
    longint p, s;
    p = n - t0;
    s = p / CLK_DIV;
    if (p < 0 || p >= FRAME) return 1'b1;
    if (s == 0) return 1'b0;
    if (s <= 8) return cur[int'(s - 1)];
`ifdef UART_TX_PARITY_EN
    if (s == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    logic v, r, pop_m, push_m;
    logic [7:0] d;
    v = bus.wr_valid;
    d = bus.wr_data;
    r = rst;
    @(posedge clk);
    #1;
    n++;
    if (r) begin
      mq.delete();
      free_at = n;
      t0 = -64'sd1000000000;
    end else begin
      pop_m = mq.size() > 0 && n >= free_at;
      push_m = v && mq.size() != DEPTH;
      if (pop_m) begin
        cur = mq.pop_front();
        t0 = n;
        free_at = n + FRAME;
      end
      if (push_m) begin
        mq.push_back(d);
        sent.push_back(d);
      end
    end
    chk("txd", bus.txd, exp_txd());
    chk("fifo_count", bus.fifo_count, mq.size());
    chk("wr_ready", bus.wr_ready, mq.size() != DEPTH);
    chk("busy", bus.busy, mq.size() != 0 || n < free_at);
    chk("irq_empty", bus.irq_empty, !(mq.size() != 0 || n < free_at));
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 12 * FRAME && bus.irq_empty !== 1'b1; i++) step();
    chk({tag, "_idle"}, bus.irq_empty, 1);
    repeat (4) step();
  endtask

  task automatic check_rx(string tag);
    chk({tag, "_frames"}, rx_q.size(), sent.size());
    for (int i = 0; i < rx_q.size() && i < sent.size(); i++) begin
      chk({tag, "_data"}, rx_q[i].d, sent[i]);
      chk({tag, "_stop"}, rx_q[i].s, 1);
`ifdef UART_TX_PARITY_EN
      chk({tag, "_parity"}, rx_q[i].p, ^sent[i]);
`endif
    end
  endtask

  initial begin
    frame_t f;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (bus.txd === 1'b0) begin
        f.t = n;
        starts++;
        repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = bus.txd;
          if (i < 7) repeat (CLK_DIV) @(negedge clk);
        end
        f.d = b;
        f.p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        f.p = bus.txd;
`endif
        repeat (CLK_DIV) @(negedge clk);
        f.s = bus.txd;
        rx_q.push_back(f);
      end
    end
  end

  initial begin
    logic [7:0] hb [8];
    longint e, w0, s0;
    hb = '{8'h48, 8'h31, 8'h48, 8'h32, 8'h48, 8'h33, 8'h44, 8'h4E};
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    repeat (3) step();
    chk("reset_txd", bus.txd, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_count", bus.fifo_count, 0);
    chk("reset_ready", bus.wr_ready, 1);
    chk("reset_irq", bus.irq_empty, 1);
    rst = 1'b0;
    step();
    bus.wr_data = 8'h48;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'hFF;
    chk("single_txd_accept", bus.txd, 1);
    step();
    e = n;
    chk("single_txd_fall", bus.txd, 0);
    repeat (FRAME - 1) step();
    chk("single_irq_before", bus.irq_empty, 0);
    step();
    chk("single_irq_end", bus.irq_empty, 1);
    chk("single_txd_end", bus.txd, 1);
    repeat (2) step();
    check_rx("single");
    chk("single_start", rx_q.size() > 0 ? rx_q[0].t - e : -1, 0);
    rx_q.delete();
    sent.delete();
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = hb[i];
      bus.wr_valid = 1'b1;
      chk("burst_ready", bus.wr_ready, 1);
      step();
    end
    bus.wr_valid = 1'b0;
    chk("burst_count", bus.fifo_count, 7);
    wait_idle("burst");
    chk("burst_bytes", sent.size(), 8);
    check_rx("burst");
    for (int i = 1; i < rx_q.size(); i++) chk("burst_gap", rx_q[i].t - rx_q[i - 1].t, FRAME);
    rx_q.delete();
    sent.delete();
    w0 = 0;
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = 8'(8'h30 + i);
      bus.wr_valid = 1'b1;
      chk("fill_ready", bus.wr_ready, 1);
      step();
      if (i == 0) w0 = n;
    end
    chk("full_count", bus.fifo_count, 8);
    chk("full_ready", bus.wr_ready, 0);
    bus.wr_data = 8'h39;
    for (int i = 0; i < FRAME + 8 && bus.wr_ready !== 1'b1; i++) step();
    chk("ready_rise", n - w0, 1 + FRAME);
    chk("drop_count", bus.fifo_count, 7);
    step();
    bus.wr_valid = 1'b0;
    chk("refill_count", bus.fifo_count, 8);
    wait_idle("ten");
    check_rx("ten");
    rx_q.delete();
    sent.delete();
    bus.wr_data = 8'h55;
    bus.wr_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = 8'(8'hA1 + i);
      step();
    end
    bus.wr_valid = 1'b0;
    repeat (4 * CLK_DIV) step();
    chk("pre_rst_count", bus.fifo_count, 3);
    s0 = starts;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_txd", bus.txd, 1);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (2 * FRAME) step();
    chk("rst_no_frames", starts - s0, 0);
    rx_q.delete();
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'($urandom);
      bus.wr_valid = 1'b1;
      step();
      bus.wr_valid = 1'b0;
      repeat ($urandom_range(0, 3 * CLK_DIV)) step();
    end
    wait_idle("rand");
    check_rx("rand");
    rx_q.delete();
    sent.delete();
`ifdef UART_TX_PARITY_EN
    bus.wr_data = 8'h07;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_data = 8'h03;
    step();
    bus.wr_valid = 1'b0;
    wait_idle("par");
    check_rx("par");
    chk("par_frames", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("par_bit0", rx_q[0].p, 1);
      chk("par_bit1", rx_q[1].p, 0);
      chk("par_len", rx_q[1].t - rx_q[0].t, 2387);
    end
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
